// File: rtl/seq_detect_fsm_if.sv
// seq_detect_fsm_if: groups the serial input, the pattern configuration and the
// detector outputs of seq_detect_fsm into one bundle.
//   master : the source side. It drives in_valid/in/pattern/overlap/load and
//            observes match/progress/count/count_sat/seg_state/seg_count.
//   slave  : the detector side (seq_detect_fsm).
// The N and CNT_W parameters must match the seq_detect_fsm instance that the
// interface is connected to.
interface seq_detect_fsm_if #(
  parameter int N     = 4,
  parameter int CNT_W = 8
);
  localparam int PW = $clog2(N + 1);

  logic             in_valid;
  logic             in;
  logic [N-1:0]     pattern;
  logic             overlap;
  logic             load;
  logic             match;
  logic [PW-1:0]    progress;
  logic [CNT_W-1:0] count;
  logic             count_sat;
  logic [6:0]       seg_state;
  logic [6:0]       seg_count;

  modport master (
    output in_valid, in, pattern, overlap, load,
    input  match, progress, count, count_sat, seg_state, seg_count
  );

  modport slave (
    input  in_valid, in, pattern, overlap, load,
    output match, progress, count, count_sat, seg_state, seg_count
  );
endinterface

// File: rtl/seq_detect_fsm.sv
// seq_detect_fsm: serial pattern detector with a runtime-programmable N-bit
// pattern, overlapping or non-overlapping detection, a saturating match counter,
// a match-progress output and two 7-segment digits.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous reset, active-high
//   bus  : seq_detect_fsm_if.slave
//          in_valid/in : serial bit, accepted on an edge where in_valid=1
//          pattern     : target, pattern[N-1] is the first bit received
//          overlap     : 1 = overlapping detection, 0 = non-overlapping
//          load        : synchronous clear of history/progress/match/count
//          match       : one-cycle pulse per detected pattern
//          progress    : matched-prefix length 0..N
//          count       : saturating match count; count_sat flags all-ones
//          seg_state   : HEX digit of progress[3:0] (active-low segments)
//          seg_count   : HEX digit of count[3:0]
// Configuration macro SEQ_DET_HEX_EN: when defined the two HEX digits are
// decoded by hex instances; when undefined both digits are driven blank (7'h7F).
// All detector outputs are registered, one cycle after the accepting edge.

`ifdef SEQ_DET_HEX_EN
// hex: 4-bit value to active-low 7-segment pattern, seg[6:0] = {g,f,e,d,c,b,a}.
module hex (
  input  logic [3:0] d,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'h7F;
    case (d)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end
endmodule
`endif

// State table (tracks how full the history window is):
//   state   | meaning
//   S_EMPTY | no valid history bits (after reset/load or a non-overlapping hit)
//   S_FILL  | 1..N-1 valid history bits
//   S_FULL  | N valid history bits, every accepted bit forms a complete window
module seq_detect_fsm #(
  parameter int N     = 4,
  parameter int CNT_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  seq_detect_fsm_if.slave bus
);
  localparam int PW = $clog2(N + 1);
  localparam logic [PW-1:0]    NFULL = PW'(N);
  localparam logic [CNT_W-1:0] CMAX  = '1;

  typedef enum logic [1:0] {S_EMPTY, S_FILL, S_FULL} state_t;

  state_t           state, state_n;
  logic [N-1:0]     hist, hist_n;
  logic [PW-1:0]    fill, fill_n;
  logic [PW-1:0]    prog, prog_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             match_r, match_n;
  logic             sat, sat_n;

  logic [N-1:0]     shifted;
  logic [N-1:0]     mask;
  logic [N-1:0]     cand;
  logic [PW-1:0]    fill_inc;
  logic [PW-1:0]    best;
  logic             hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_EMPTY;
      hist    <= '0;
      fill    <= '0;
      prog    <= '0;
      cnt     <= '0;
      match_r <= 1'b0;
      sat     <= 1'b0;
    end else begin
      state   <= state_n;
      hist    <= hist_n;
      fill    <= fill_n;
      prog    <= prog_n;
      cnt     <= cnt_n;
      match_r <= match_n;
      sat     <= sat_n;
    end
  end

  always_comb begin
    shifted  = {hist[N-2:0], bus.in};
    fill_inc = (state == S_FULL) ? NFULL : fill + 1'b1;
    hit      = (fill_inc == NFULL) && (shifted == bus.pattern);

    // Longest suffix of the new history that equals a prefix of the pattern,
    // limited to the bits actually received since the last clear.
    best = '0;
    mask = '0;
    cand = '0;
    for (int k = 1; k <= N; k++) begin
      mask = {N{1'b1}} >> (N - k);
      cand = bus.pattern >> (N - k);
      if ((PW'(k) <= fill_inc) && (((shifted ^ cand) & mask) == '0)) begin
        best = PW'(k);
      end
    end

    state_n = state;
    hist_n  = hist;
    fill_n  = fill;
    prog_n  = prog;
    cnt_n   = cnt;
    sat_n   = sat;
    match_n = 1'b0;

    if (bus.load) begin
      hist_n = '0;
      fill_n = '0;
      prog_n = '0;
      cnt_n  = '0;
      sat_n  = 1'b0;
    end else if (bus.in_valid) begin
      hist_n = shifted;
      if (hit) begin
        match_n = 1'b1;
        prog_n  = NFULL;
        cnt_n   = (cnt == CMAX) ? cnt : cnt + 1'b1;
        sat_n   = (cnt_n == CMAX);
        // Non-overlapping mode restarts the window; the stale hist bits are
        // harmless because fill gates both hit and progress.
        fill_n  = bus.overlap ? NFULL : '0;
      end else begin
        fill_n = fill_inc;
        prog_n = best;
      end
    end

    if (fill_n == '0) begin
      state_n = S_EMPTY;
    end else if (fill_n == NFULL) begin
      state_n = S_FULL;
    end else begin
      state_n = S_FILL;
    end
  end

  assign bus.match     = match_r;
  assign bus.progress  = prog;
  assign bus.count     = cnt;
  assign bus.count_sat = sat;

`ifdef SEQ_DET_HEX_EN
  logic [3:0] prog_nib;
  logic [3:0] cnt_nib;

  if (PW >= 4) begin : g_prog_nib
    assign prog_nib = prog[3:0];
  end else begin : g_prog_nib
    assign prog_nib = {{(4 - PW){1'b0}}, prog};
  end

  if (CNT_W >= 4) begin : g_cnt_nib
    assign cnt_nib = cnt[3:0];
  end else begin : g_cnt_nib
    assign cnt_nib = {{(4 - CNT_W){1'b0}}, cnt};
  end

  hex u_hex_state (.d(prog_nib), .seg(bus.seg_state));
  hex u_hex_count (.d(cnt_nib),  .seg(bus.seg_count));
`else
  assign bus.seg_state = 7'h7F;
  assign bus.seg_count = 7'h7F;
`endif
endmodule

// File: tb/tb_seq_detect_fsm.sv
module tb_seq_detect_fsm;
  logic clk;
  logic rst;

  seq_detect_fsm_if #(.N(4), .CNT_W(8)) bus1 ();
  seq_detect_fsm_if #(.N(2), .CNT_W(2)) bus2 ();

  seq_detect_fsm #(.N(4), .CNT_W(8)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  seq_detect_fsm #(.N(2), .CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errs    = 0;

  // Reference model for the N=4, CNT_W=8 instance: the bits accepted since the
  // last clear, trimmed to the last N.
  bit mq[$];
  int m_count = 0;
  int m_prog  = 0;
  bit m_match = 0;

  typedef struct {
    logic ld;
    logic v;
    logic b;
    logic ov;
    logic m;
    int   p;
    int   c;
  } vec_t;
  vec_t tbl[$];

  function automatic int hexseg(input int d);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return int'(t[d & 15]);
  endfunction

  function automatic int exp_seg(input int d);
`ifdef SEQ_DET_HEX_EN
    return hexseg(d);
`else
    return (d >= 0) ? 'h7F : 'h7F;
`endif
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  task automatic model_update();
    bit hit;
    int n;
    if (rst || bus1.load) begin
      mq.delete();
      m_count = 0;
      m_prog  = 0;
      m_match = 0;
    end else if (bus1.in_valid) begin
      mq.push_back(bus1.in);
      if (mq.size() > 4) void'(mq.pop_front());
      n = mq.size();
      hit = (n == 4);
      for (int i = 0; i < n; i++)
        if (mq[i] != bus1.pattern[3-i]) hit = 0;
      if (hit) begin
        m_match = 1;
        m_prog  = 4;
        if (m_count < 255) m_count++;
        if (!bus1.overlap) mq.delete();
      end else begin
        m_match = 0;
        m_prog  = 0;
        for (int k = 1; k <= n; k++) begin
          bit ok = 1;
          for (int j = 0; j < k; j++)
            if (mq[n-k+j] != bus1.pattern[3-j]) ok = 0;
          if (ok) m_prog = k;
        end
      end
    end else begin
      m_match = 0;
    end
  endtask

  task automatic step(input logic r, input logic ld, input logic v, input logic b);
    rst           = r;
    bus1.load     = ld;
    bus1.in_valid = v;
    bus1.in       = b;
    @(posedge clk);
    model_update();
    #1;
    chk("match",     int'(bus1.match),     int'(m_match));
    chk("progress",  int'(bus1.progress),  m_prog);
    chk("count",     int'(bus1.count),     m_count);
    chk("count_sat", int'(bus1.count_sat), int'(m_count == 255));
    chk("seg_state", int'(bus1.seg_state), exp_seg(m_prog));
    chk("seg_count", int'(bus1.seg_count), exp_seg(m_count));
  endtask

  task automatic step2(input logic ld, input logic v, input logic b);
    bus2.load     = ld;
    bus2.in_valid = v;
    bus2.in       = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit seq7 [7];
    int pulses;
    int last_c;
    int last_p;
    seq7 = '{1, 0, 1, 1, 0, 1, 1};

    rst = 1'b1;
    bus1.in_valid = 0; bus1.in = 0; bus1.load = 0;
    bus1.pattern = 4'b1011; bus1.overlap = 1;
    bus2.in_valid = 0; bus2.in = 0; bus2.load = 0;
    bus2.pattern = 2'b11; bus2.overlap = 1;

    // reset state
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("reset_progress", int'(bus1.progress), 0);
    chk("reset_count",    int'(bus1.count),    0);
    chk("reset_seg",      int'(bus1.seg_state), exp_seg(0));

    // table: overlapping run, non-overlapping run, load-with-valid discard
    tbl.push_back('{1, 0, 0, 1, 0, 0, 0});
    tbl.push_back('{0, 1, 1, 1, 0, 1, 0});
    tbl.push_back('{0, 1, 0, 1, 0, 2, 0});
    tbl.push_back('{0, 1, 1, 1, 0, 3, 0});
    tbl.push_back('{0, 1, 1, 1, 1, 4, 1});
    tbl.push_back('{0, 1, 0, 1, 0, 2, 1});
    tbl.push_back('{0, 1, 1, 1, 0, 3, 1});
    tbl.push_back('{0, 1, 1, 1, 1, 4, 2});
    tbl.push_back('{1, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 1, 0, 0, 1, 0});
    tbl.push_back('{0, 1, 0, 0, 0, 2, 0});
    tbl.push_back('{0, 1, 1, 0, 0, 3, 0});
    tbl.push_back('{0, 1, 1, 0, 1, 4, 1});
    tbl.push_back('{0, 1, 0, 0, 0, 0, 1});
    tbl.push_back('{0, 1, 1, 0, 0, 1, 1});
    tbl.push_back('{0, 1, 1, 0, 0, 1, 1});
    tbl.push_back('{1, 0, 0, 1, 0, 0, 0});
    tbl.push_back('{0, 1, 1, 1, 0, 1, 0});
    tbl.push_back('{0, 1, 0, 1, 0, 2, 0});
    tbl.push_back('{0, 1, 1, 1, 0, 3, 0});
    tbl.push_back('{1, 1, 1, 1, 0, 0, 0});
    tbl.push_back('{0, 1, 1, 1, 0, 1, 0});
    tbl.push_back('{0, 1, 0, 1, 0, 2, 0});
    tbl.push_back('{0, 1, 1, 1, 0, 3, 0});
    tbl.push_back('{0, 1, 1, 1, 1, 4, 1});

    foreach (tbl[i]) begin
      bus1.overlap = tbl[i].ov;
      step(0, tbl[i].ld, tbl[i].v, tbl[i].b);
      chk($sformatf("tbl[%0d].match", i),    int'(bus1.match),    int'(tbl[i].m));
      chk($sformatf("tbl[%0d].progress", i), int'(bus1.progress), tbl[i].p);
      chk($sformatf("tbl[%0d].count", i),    int'(bus1.count),    tbl[i].c);
    end

    // in_valid toggling: two one-cycle pulses, outputs hold while idle
    bus1.overlap = 1;
    step(0, 1, 0, 0);
    pulses = 0;
    for (int i = 0; i < 7; i++) begin
      step(0, 0, 1, seq7[i]);
      if (bus1.match) pulses++;
      last_c = int'(bus1.count);
      last_p = int'(bus1.progress);
      step(0, 0, 0, ~seq7[i]);
      chk("idle_match_low", int'(bus1.match),    0);
      chk("idle_count",     int'(bus1.count),    last_c);
      chk("idle_progress",  int'(bus1.progress), last_p);
    end
    chk("toggle_pulses", pulses, 2);
    chk("toggle_count",  int'(bus1.count), 2);

    // N=2, CNT_W=2, pattern 11 overlapping: saturation with continued pulses
    step2(1, 0, 0);
    for (int j = 1; j <= 6; j++) begin
      step2(0, 1, 1);
      chk($sformatf("sat_match[%0d]", j), int'(bus2.match), int'(j >= 2));
      chk($sformatf("sat_count[%0d]", j), int'(bus2.count), (j - 1 > 3) ? 3 : j - 1);
      chk($sformatf("sat_flag[%0d]", j),  int'(bus2.count_sat), int'(j >= 4));
      chk($sformatf("sat_prog[%0d]", j),  int'(bus2.progress), (j == 1) ? 1 : 2);
    end
    step2(0, 0, 0);
    chk("sat_match_drop", int'(bus2.match), 0);
    chk("sat_count_hold", int'(bus2.count), 3);

    // reset mid-pattern: progress discarded, N fresh bits needed
    bus1.pattern = 4'b1011;
    step(0, 1, 0, 0);
    step(0, 0, 1, 1);
    step(0, 0, 1, 0);
    step(0, 0, 1, 1);
    step(1, 0, 0, 0);
    chk("rst_seg_state", int'(bus1.seg_state), exp_seg(0));
    chk("rst_seg_count", int'(bus1.seg_count), exp_seg(0));
    step(0, 0, 1, 1);
    chk("rst_then1_match", int'(bus1.match),    0);
    chk("rst_then1_prog",  int'(bus1.progress), 1);
    step(0, 0, 1, 0);
    step(0, 0, 1, 1);
    step(0, 0, 1, 1);
    chk("rst_refill_match", int'(bus1.match), 1);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic r, ld, v, b;
      r  = ($urandom_range(0, 127) == 0);
      ld = 0;
      if ($urandom_range(0, 63) == 0) begin
        bus1.pattern = 4'($urandom_range(0, 15));
        bus1.overlap = 1'($urandom_range(0, 1));
        ld = 1;
      end else if ($urandom_range(0, 99) == 0) begin
        ld = 1;
      end
      v = ($urandom_range(0, 9) < 7);
      b = 1'($urandom_range(0, 1));
      step(r, ld, v, b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
